// File: rtl/is_pkg_uart_controller.sv
// Shared UART frame layout and types for the RX/TX datapath.
package is_pkg_uart_controller;

    localparam int UART_FRAME_W  = 10;
    localparam int FRM_START_BIT = 0;
    localparam int FRM_DATA_LSB  = 1;
    localparam int FRM_DATA_MSB  = 8;
    localparam int FRM_STOP_BIT  = 9;

    typedef logic [UART_FRAME_W-1:0]              uart_frame_t;
    typedef logic [FRM_DATA_MSB-FRM_DATA_LSB:0]   uart_byte_t;

    // A frame is good when the start bit is low and the stop bit is high.
    function automatic logic frame_ok(input uart_frame_t f);
        return !f[FRM_START_BIT] && f[FRM_STOP_BIT];
    endfunction

    // Payload byte with start/stop stripped, LSB-first order preserved.
    function automatic uart_byte_t frame_data(input uart_frame_t f);
        return f[FRM_DATA_MSB:FRM_DATA_LSB];
    endfunction

endpackage

// File: rtl/is_uart_fifo.sv
// First-word-fall-through byte FIFO: storage, wrapping pointers, occupancy.
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle; otherwise it is discarded and flagged on drop.
module is_uart_fifo
    import is_pkg_uart_controller::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  uart_byte_t               push_data,
    input  logic                     pop,
    output logic                     valid,
    output uart_byte_t               data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    uart_byte_t           mem [DEPTH];
    logic [AW-1:0]        wp;
    logic [AW-1:0]        rp;
    logic [CW-1:0]        cnt;
    logic                 empty;
    logic                 full;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Outputs come only from registered state, so there is no input-to-output path.
    assign valid = !empty;
    assign data  = empty ? '0 : mem[rp];
    assign count = cnt;

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= push_data;
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracked separately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push)
                wp <= wp + AW'(1);
            if (do_pop)
                rp <= rp + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/is_uart_rx_buf.sv
// Receive buffer between the RX FSM and the TX FSM (echo path): checks
// frames, queues payload bytes, and keeps error/drop statistics.
module is_uart_rx_buf
    import is_pkg_uart_controller::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rx_data_en_i,
    input  uart_frame_t             rx_data_t_i,
    output logic                    tx_rdy_t_o,
    output uart_byte_t              tx_data_t_o,
    input  logic                    tx_rdy_r_i,
    input  logic                    clr_i,
    output logic [$clog2(DEPTH):0]  fifo_cnt_o,
    output logic [CNT_W-1:0]        frame_err_cnt_o,
    output logic [CNT_W-1:0]        drop_cnt_o,
    output logic                    ovf_o
);

    logic frame_good;
    logic frame_bad;
    logic drop;

    assign frame_good = rx_data_en_i &&  frame_ok(rx_data_t_i);
    assign frame_bad  = rx_data_en_i && !frame_ok(rx_data_t_i);

    // The FIFO ignores pop while empty, so ready can be passed straight through.
    is_uart_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (frame_good),
        .push_data (frame_data(rx_data_t_i)),
        .pop       (tx_rdy_r_i),
        .valid     (tx_rdy_t_o),
        .data      (tx_data_t_o),
        .count     (fifo_cnt_o),
        .drop      (drop)
    );

    // Saturating statistics and sticky overflow; clear beats a same-cycle increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_err_cnt_o <= '0;
            drop_cnt_o      <= '0;
            ovf_o           <= 1'b0;
        end else if (clr_i) begin
            frame_err_cnt_o <= '0;
            drop_cnt_o      <= '0;
            ovf_o           <= 1'b0;
        end else begin
            if (frame_bad && (frame_err_cnt_o != '1))
                frame_err_cnt_o <= frame_err_cnt_o + CNT_W'(1);
            if (drop && (drop_cnt_o != '1))
                drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            if (drop)
                ovf_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_is_uart_rx_buf.sv
// Directed self-checking bench for is_uart_rx_buf (DEPTH=16, CNT_W=8).
module tb_is_uart_rx_buf;

    logic       clk;
    logic       rst;
    logic       rx_en;
    logic [9:0] rx_frame;
    logic       tx_rdy_t;
    logic [7:0] tx_data;
    logic       tx_rdy_r;
    logic       clr;
    logic [4:0] fifo_cnt;
    logic [7:0] err_cnt;
    logic [7:0] drop_cnt;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    is_uart_rx_buf #(.DEPTH(16), .CNT_W(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rx_data_en_i    (rx_en),
        .rx_data_t_i     (rx_frame),
        .tx_rdy_t_o      (tx_rdy_t),
        .tx_data_t_o     (tx_data),
        .tx_rdy_r_i      (tx_rdy_r),
        .clr_i           (clr),
        .fifo_cnt_o      (fifo_cnt),
        .frame_err_cnt_o (err_cnt),
        .drop_cnt_o      (drop_cnt),
        .ovf_o           (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle with the given frame strobed; returns #1 after the edge.
    task automatic strobe(input logic [9:0] f, input logic rdy);
        rx_en    = 1'b1;
        rx_frame = f;
        tx_rdy_r = rdy;
        @(posedge clk); #1;
        rx_en    = 1'b0;
        tx_rdy_r = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (tx_rdy_t !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b exp 0", tx_rdy_t); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", tx_data); end
        n_checks++; if (fifo_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", fifo_cnt); end
        n_checks++; if ({err_cnt, drop_cnt, ovf} !== 17'd0) begin n_fail++; $display("FAIL reset_stats got %h/%h/%b exp 0", err_cnt, drop_cnt, ovf); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        strobe(10'b1_01010101_0, 1'b0);
        n_checks++; if (tx_rdy_t !== 1'b1) begin n_fail++; $display("FAIL basic_rdy got %b exp 1", tx_rdy_t); end
        n_checks++; if (tx_data !== 8'h55) begin n_fail++; $display("FAIL basic_data got %h exp 55", tx_data); end
        n_checks++; if (fifo_cnt !== 5'd1) begin n_fail++; $display("FAIL basic_cnt got %0d exp 1", fifo_cnt); end
        tx_rdy_r = 1'b1;
        @(posedge clk); #1;
        tx_rdy_r = 1'b0;
        n_checks++; if ({tx_rdy_t, tx_data, fifo_cnt} !== 14'd0) begin n_fail++; $display("FAIL basic_pop got rdy=%b data=%h cnt=%0d exp 0", tx_rdy_t, tx_data, fifo_cnt); end
    endtask

    task automatic test_bad_frames();
        strobe(10'b1_00001111_1, 1'b0);
        strobe(10'b0_00001111_0, 1'b0);
        n_checks++; if (fifo_cnt !== 5'd0) begin n_fail++; $display("FAIL bad_cnt got %0d exp 0", fifo_cnt); end
        n_checks++; if (tx_rdy_t !== 1'b0) begin n_fail++; $display("FAIL bad_rdy got %b exp 0", tx_rdy_t); end
        n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL bad_errcnt got %0d exp 2", err_cnt); end
    endtask

    task automatic test_full();
        logic [7:0] exp_q [$];
        for (int b = 1; b <= 16; b++) strobe({1'b1, 8'(b), 1'b0}, 1'b0);
        n_checks++; if (fifo_cnt !== 5'd16) begin n_fail++; $display("FAIL full_cnt got %0d exp 16", fifo_cnt); end
        n_checks++; if (tx_data !== 8'h01) begin n_fail++; $display("FAIL full_head got %h exp 01", tx_data); end
        strobe({1'b1, 8'h11, 1'b0}, 1'b0);
        n_checks++; if (fifo_cnt !== 5'd16) begin n_fail++; $display("FAIL drop_cnt_occ got %0d exp 16", fifo_cnt); end
        n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_cnt got %0d exp 1", drop_cnt); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL drop_ovf got %b exp 1", ovf); end
        // Full with simultaneous push and pop: both proceed, nothing dropped.
        strobe({1'b1, 8'hAA, 1'b0}, 1'b1);
        n_checks++; if (fifo_cnt !== 5'd16) begin n_fail++; $display("FAIL fullpp_cnt got %0d exp 16", fifo_cnt); end
        n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL fullpp_drop got %0d exp 1", drop_cnt); end
        n_checks++; if (tx_data !== 8'h02) begin n_fail++; $display("FAIL fullpp_head got %h exp 02", tx_data); end
        // Clear stats; queued data must survive.
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        n_checks++; if ({drop_cnt, ovf, err_cnt} !== 17'd0) begin n_fail++; $display("FAIL clr_stats got %h/%b/%h exp 0", drop_cnt, ovf, err_cnt); end
        n_checks++; if (fifo_cnt !== 5'd16) begin n_fail++; $display("FAIL clr_keep got %0d exp 16", fifo_cnt); end
        for (int b = 2; b <= 16; b++) exp_q.push_back(8'(b));
        exp_q.push_back(8'hAA);
        tx_rdy_r = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (tx_rdy_t !== 1'b1 || tx_data !== exp_q[i]) begin n_fail++; $display("FAIL drain[%0d] got rdy=%b %h exp 1 %h", i, tx_rdy_t, tx_data, exp_q[i]); end
            @(posedge clk); #1;
        end
        // Ready held while empty is ignored.
        @(posedge clk); #1;
        tx_rdy_r = 1'b0;
        n_checks++; if (fifo_cnt !== 5'd0 || tx_rdy_t !== 1'b0) begin n_fail++; $display("FAIL drain_empty got cnt=%0d rdy=%b exp 0 0", fifo_cnt, tx_rdy_t); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        tx_rdy_r = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_en    = 1'b1;
            rx_frame = {1'b1, b, 1'b0};
            @(posedge clk); #1;
            n_checks++; if (tx_rdy_t !== 1'b1 || tx_data !== b || fifo_cnt !== 5'd1) begin n_fail++; $display("FAIL stream[%0d] got rdy=%b %h cnt=%0d exp 1 %h 1", i, tx_rdy_t, tx_data, fifo_cnt, b); end
        end
        rx_en = 1'b0;
        @(posedge clk); #1;
        tx_rdy_r = 1'b0;
        n_checks++; if (fifo_cnt !== 5'd0) begin n_fail++; $display("FAIL stream_end got %0d exp 0", fifo_cnt); end
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 5; b++) strobe({1'b1, 8'(8'h30 + b), 1'b0}, 1'b0);
        n_checks++; if (fifo_cnt !== 5'd5) begin n_fail++; $display("FAIL mid_cnt got %0d exp 5", fifo_cnt); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (fifo_cnt !== 5'd0 || tx_rdy_t !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_async got cnt=%0d rdy=%b %h exp 0 0 00", fifo_cnt, tx_rdy_t, tx_data); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_saturate_clear();
        rx_en    = 1'b1;
        rx_frame = 10'b0_11110000_0;
        repeat (300) begin @(posedge clk); #1; end
        n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_err got %0d exp 255", err_cnt); end
        n_checks++; if (fifo_cnt !== 5'd0) begin n_fail++; $display("FAIL sat_cnt got %0d exp 0", fifo_cnt); end
        // Clear coincides with another bad frame: clear wins.
        clr = 1'b1;
        @(posedge clk); #1;
        clr   = 1'b0;
        rx_en = 1'b0;
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_err got %0d exp 0", err_cnt); end
        @(posedge clk); #1;
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_hold got %0d exp 0", err_cnt); end
    endtask

    initial begin
        rst      = 1'b1;
        rx_en    = 1'b0;
        rx_frame = '0;
        tx_rdy_r = 1'b0;
        clr      = 1'b0;
        test_reset();
        test_basic();
        test_bad_frames();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_saturate_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/is_uart_rx_buf.md
Name: is_uart_rx_buf

Overview:
- Sits downstream of the RX FSM's STP output (rx_data_en / 10-bit rx_data_t) and upstream of the TX FSM's DRP input (tx_rdy_t / tx_data_r / tx_rdy_r).
- Checks each received frame, strips start/stop bits and buffers the payload bytes in a FIFO.
- Presents the bytes to the transmitter through a valid/ready handshake, which forms the board's echo/loopback path.
- Reports framing errors and overflow for the status LEDs/debug.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, 2..256.
- CNT_W, 8, width of the saturating error/drop counters.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- rx_data_en_i  in  1  one-cycle strobe: rx_data_t_i holds a complete frame.
- rx_data_t_i  in  10  frame: [0] start, [8:1] data LSB-first, [9] stop.
- tx_rdy_t_o  out  1  byte available for the TX FSM (valid).
- tx_data_t_o  out  8  byte presented to the TX FSM.
- tx_rdy_r_i  in  1  TX FSM accepts the byte (ready).
- clr_i  in  1  synchronous clear of the counters and the sticky flag; FIFO contents are kept.
- fifo_cnt_o  out  $clog2(DEPTH)+1  current occupancy.
- frame_err_cnt_o  out  CNT_W  saturating count of rejected frames.
- drop_cnt_o  out  CNT_W  saturating count of valid bytes lost to a full FIFO.
- ovf_o  out  1  sticky: at least one byte was dropped.

Behaviour:
- Reset (async, rst_i=1): pointers=0, fifo_cnt_o=0, tx_rdy_t_o=0, tx_data_t_o=0, counters=0, ovf_o=0. Storage contents are don't-care.
- Frame check, on rx_data_en_i=1:
  - valid = (rx_data_t_i[0]==0) && (rx_data_t_i[9]==1).
  - Valid frame: request a push of rx_data_t_i[8:1].
  - Invalid frame: no push; frame_err_cnt_o increments, saturating at all-ones.
- Pop: occurs when tx_rdy_t_o && tx_rdy_r_i in the same cycle; the read pointer advances.
- Output:
  - tx_rdy_t_o = (fifo_cnt_o != 0).
  - tx_data_t_o = mem[rd_ptr] (first-word-fall-through). It is driven from registered state only, with no combinational path from any input.
  - tx_data_t_o reads 0 when empty.
  - Once asserted, tx_rdy_t_o and tx_data_t_o stay stable until the pop.
- Latency: a byte pushed in cycle N is visible on tx_rdy_t_o/tx_data_t_o in cycle N+1 if the FIFO was empty. There is no bypass within the same cycle.
- Pointers: the write pointer (WP) and read pointer (RP) are each $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is kept in a separate counter of $clog2(DEPTH)+1 bits.
- Push and pop in the same cycle:
  - Not empty: both take effect and occupancy is unchanged.
  - Empty: only the push takes effect; the pop is impossible because tx_rdy_t_o=0.
  - Full: the pop frees a slot, so the push is accepted. Nothing is dropped and ovf_o does not change.
- Full, with a push and no pop: the byte is discarded, drop_cnt_o increments (saturating), and ovf_o is set to 1.
- clr_i=1: clears frame_err_cnt_o, drop_cnt_o and ovf_o in the next cycle. If an increment coincides with clr_i, the clear wins.
- tx_rdy_r_i while empty: ignored.
- rx_data_en_i held high for more than one cycle: each high cycle is treated as a separate frame. The RX FSM guarantees single-cycle strobes.
- Reset mid-operation: all queued bytes are lost and tx_rdy_t_o drops immediately (async). The TX FSM aborts its own transfer on the same reset.

Decomposition:
- Add to is_pkg_uart_controller:
  - UART_FRAME_W=10, FRM_START_BIT=0, FRM_DATA_LSB=1, FRM_DATA_MSB=8, FRM_STOP_BIT=9.
  - typedef uart_frame_t (logic [9:0]) and uart_byte_t (logic [7:0]).
- The RX FSM and this block must both use these constants.
- One sub-module, is_uart_fifo: a parametrised synchronous FIFO containing the storage array, pointers and occupancy.
- The top of is_uart_rx_buf keeps the frame check, the counters and the sticky flag.
- is_uart_controller gains an instance of is_uart_rx_buf. It wires rx_data_en_o/rx_data_t_o into it and its tx_rdy_t_o/tx_data_t_o/tx_rdy_r_i to the TX FSM. The external reset is inverted for this block.

Test Plan:
- Reset, then hold tx_rdy_r_i=0 and strobe frame 10'b1_01010101_0 -> next cycle: tx_rdy_t_o=1, tx_data_t_o=8'h55, fifo_cnt_o=1.
- Strobe frames with bad start (10'b1_00001111_1) and bad stop (10'b0_00001111_0) -> no push, fifo_cnt_o unchanged, frame_err_cnt_o=2.
- Push 0x01..0x10 with DEPTH=16, then push 0x11 with ready=0 -> fifo_cnt_o=16, drop_cnt_o=1, ovf_o=1. Draining yields exactly 0x01..0x10 in order.
- FIFO full, push 0xAA and assert tx_rdy_r_i in the same cycle -> 0x01 is popped, 0xAA accepted, fifo_cnt_o stays 16, drop_cnt_o unchanged. The last drained byte is 0xAA.
- Continuous ready=1 with 40 random valid frames (pointer wrap) -> output sequence equals input sequence; each byte is presented one cycle after its push.
- Assert rst_i mid-stream with 5 bytes queued -> fifo_cnt_o=0 and tx_rdy_t_o=0 asynchronously. Then clr_i after 300 bad frames -> frame_err_cnt_o saturates at 255 before the clear and reads 0 after it.
